tri_bbox_scanner: RTL and testbench

Upstream feeder for the triangle edge-test slave. Accepts three triangle vertices and a start pulse, then computes the vertices' screen-clamped bounding box. It streams every pixel coordinate in that box, in row-major order, over a valid/ready handshake, at up to one pixel per clock. The downstream stage performs the inside test on each (x,y) it accepts.

---
 rtl/tri_bbox_scanner.sv | 179 +++++++++++++++++
 tb/tb_tri_bbox_scanner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tri_bbox_scanner.sv
// Triangle bounding-box scanner: latches three vertices, clamps their bounding box
// to the screen and streams every pixel of it in row-major order over valid/ready.
module tri_bbox_scanner #(
    parameter int COORD_W = 16,
    parameter int MAX_X   = 319,
    parameter int MAX_Y   = 239
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic signed [COORD_W-1:0] x3,
    input  logic signed [COORD_W-1:0] y3,
    output logic                      busy,
    output logic                      done,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [COORD_W-1:0]        pix_x,
    output logic [COORD_W-1:0]        pix_y,
    output logic                      pix_last
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

    localparam logic signed [COORD_W-1:0] LIM_X = COORD_W'(MAX_X);
    localparam logic signed [COORD_W-1:0] LIM_Y = COORD_W'(MAX_Y);
    localparam logic [COORD_W-1:0]        ONE   = COORD_W'(1);

    function automatic logic signed [COORD_W-1:0] min3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c
    );
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c
    );
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] clamp(
        input logic signed [COORD_W-1:0] v,
        input logic signed [COORD_W-1:0] hi
    );
        if (v[COORD_W-1]) return '0;
        if (v > hi)       return hi;
        return v;
    endfunction

    state_t r_state, w_state_next;

    logic signed [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic [COORD_W-1:0]        r_xmin, r_xmax, r_ymax;
    logic [COORD_W-1:0]        r_cx, r_cy;
    logic                      r_busy, r_done, r_pix_valid, r_pix_last;

    logic signed [COORD_W-1:0] w_xmin_raw, w_xmax_raw, w_ymin_raw, w_ymax_raw;
    logic [COORD_W-1:0]        w_xmin_c, w_xmax_c, w_ymin_c, w_ymax_c;
    logic [COORD_W-1:0]        w_cx_inc, w_cy_inc;
    logic                      w_empty, w_hs, w_row_end, w_last_row;

    assign w_xmin_raw = min3(r_x1, r_x2, r_x3);
    assign w_xmax_raw = max3(r_x1, r_x2, r_x3);
    assign w_ymin_raw = min3(r_y1, r_y2, r_y3);
    assign w_ymax_raw = max3(r_y1, r_y2, r_y3);

    assign w_xmin_c = clamp(w_xmin_raw, LIM_X);
    assign w_xmax_c = clamp(w_xmax_raw, LIM_X);
    assign w_ymin_c = clamp(w_ymin_raw, LIM_Y);
    assign w_ymax_c = clamp(w_ymax_raw, LIM_Y);

    // Emptiness must be judged before clamping, otherwise an off-screen box collapses onto an edge.
    assign w_empty = w_xmax_raw[COORD_W-1] || (w_xmin_raw > LIM_X) ||
                     w_ymax_raw[COORD_W-1] || (w_ymin_raw > LIM_Y);

    assign w_hs       = r_pix_valid && pix_ready;
    assign w_row_end  = (r_cx == r_xmax);
    assign w_last_row = (r_cy == r_ymax);
    assign w_cx_inc   = r_cx + ONE;
    assign w_cy_inc   = r_cy + ONE;

    // NOTE: the state register is the only thing in this block; all decisions live in always_comb.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: default assigned first so no path through the case leaves w_state_next unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SETUP;
            S_SETUP: w_state_next = w_empty ? S_DONE : S_SCAN;
            S_SCAN:  if (w_hs && w_row_end && w_last_row) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_x1        <= '0;
            r_y1        <= '0;
            r_x2        <= '0;
            r_y2        <= '0;
            r_x3        <= '0;
            r_y3        <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymax      <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x1 <= x1;
                        r_y1 <= y1;
                        r_x2 <= x2;
                        r_y2 <= y2;
                        r_x3 <= x3;
                        r_y3 <= y3;
                    end
                end
                S_SETUP: begin
                    r_xmin      <= w_xmin_c;
                    r_xmax      <= w_xmax_c;
                    r_ymax      <= w_ymax_c;
                    r_cx        <= w_xmin_c;
                    r_cy        <= w_ymin_c;
                    r_pix_valid <= !w_empty;
                    r_pix_last  <= !w_empty && (w_xmin_c == w_xmax_c) && (w_ymin_c == w_ymax_c);
                end
                S_SCAN: begin
                    if (w_hs) begin
                        if (!w_row_end) begin
                            r_cx       <= w_cx_inc;
                            r_pix_last <= (w_cx_inc == r_xmax) && w_last_row;
                        end else if (!w_last_row) begin
                            r_cx       <= r_xmin;
                            r_cy       <= w_cy_inc;
                            r_pix_last <= (r_xmin == r_xmax) && (w_cy_inc == r_ymax);
                        end else begin
                            r_pix_valid <= 1'b0;
                            r_pix_last  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_valid = r_pix_valid;
    assign pix_x     = r_cx;
    assign pix_y     = r_cy;
    assign pix_last  = r_pix_last;

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Self-checking bench for tri_bbox_scanner: directed jobs plus random jobs compared
// against a box-enumeration reference model, with random downstream back-pressure.
module tb_tri_bbox_scanner;

    localparam int COORD_W = 16;
    localparam int MAX_X   = 319;
    localparam int MAX_Y   = 239;

    logic                      HCLK = 1'b0;
    logic                      HRESETn = 1'b0;
    logic                      start = 1'b0;
    logic signed [COORD_W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
    logic                      busy, done, pix_valid, pix_last;
    logic                      pix_ready = 1'b0;
    logic [COORD_W-1:0]        pix_x, pix_y;

    int n_checks = 0;
    int n_pass   = 0;

    tri_bbox_scanner #(.COORD_W(COORD_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: enumerate the clamped box with plain integer arithmetic.
    function automatic void build_expected(input int vx[3], input int vy[3], output logic [32:0] q[$]);
        int xmn, xmx, ymn, ymx;
        q = {};
        xmn = vx[0]; xmx = vx[0]; ymn = vy[0]; ymx = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < xmn) xmn = vx[i];
            if (vx[i] > xmx) xmx = vx[i];
            if (vy[i] < ymn) ymn = vy[i];
            if (vy[i] > ymx) ymx = vy[i];
        end
        if (xmx < 0 || xmn > MAX_X || ymx < 0 || ymn > MAX_Y) return;
        if (xmn < 0) xmn = 0;
        if (xmx > MAX_X) xmx = MAX_X;
        if (ymn < 0) ymn = 0;
        if (ymx > MAX_Y) ymx = MAX_Y;
        for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++)
                q.push_back({(x == xmx && y == ymx), y[15:0], x[15:0]});
    endfunction

    // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic run_job(input int vx[3], input int vy[3], input int mode,
                           input bit poke_start, input int abort_after);
        logic [32:0] exp_q[$];
        int  cyc, n_seen, n_total, last_hs, first;
        bit  got_done, rdy;
        build_expected(vx, vy, exp_q);
        n_total = exp_q.size();
        @(negedge HCLK);
        x1 = vx[0][15:0]; y1 = vy[0][15:0];
        x2 = vx[1][15:0]; y2 = vy[1][15:0];
        x3 = vx[2][15:0]; y3 = vy[2][15:0];
        start = 1'b1;
        pix_ready = 1'b0;
        @(negedge HCLK);
        start = 1'b0;
        cyc = 1; n_seen = 0; last_hs = 0; first = -1; got_done = 1'b0;
        check("busy_after_start", busy, 1);
        check("setup_no_valid", pix_valid, 0);
        while (!got_done && cyc < 3000) begin
            @(negedge HCLK);
            cyc++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc + 1) % 3 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            pix_ready = rdy;
            if (poke_start && cyc == 4) begin
                start = 1'b1;
                x1 = 16'sd100; y1 = 16'sd100; x2 = 16'sd110; y2 = 16'sd100; x3 = 16'sd105; y3 = 16'sd110;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                check("done_no_valid", pix_valid, 0);
                check("busy_in_done", busy, 1);
                check("all_pixels_seen", n_seen, n_total);
                if (n_total > 0) check("done_after_last", cyc, last_hs + 1);
                else             check("empty_done_cycle", cyc, 2);
            end else if (pix_valid) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_latency", cyc, 2);
                end
                if (exp_q.size() == 0) check("pixel_count", n_seen + 1, n_total);
                else                   check("pixel", {pix_last, pix_y, pix_x}, exp_q[0]);
                check("busy_in_scan", busy, 1);
                if (rdy && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    n_seen++;
                    last_hs = cyc;
                    if (abort_after > 0 && n_seen == abort_after) begin
                        @(posedge HCLK);
                        #2 HRESETn = 1'b0;
                        #1 check("abort_outputs_zero",
                                 {busy, done, pix_valid, pix_last, pix_x, pix_y}, 0);
                        pix_ready = 1'b0;
                        start = 1'b0;
                        for (int k = 0; k < 3; k++) begin
                            @(negedge HCLK);
                            check("abort_no_done", {done, busy}, 0);
                        end
                        HRESETn = 1'b1;
                        return;
                    end
                end
            end else if (first >= 0) begin
                check("valid_held", pix_valid, 1);
            end
        end
        check("job_done", got_done, 1);
        start = 1'b0;
        pix_ready = 1'b0;
        @(negedge HCLK);
        check("done_one_cycle", done, 0);
        check("idle_not_busy", busy, 0);
        if (poke_start) begin
            repeat (6) @(negedge HCLK);
            check("no_second_job", {busy, pix_valid, done}, 0);
        end
    endtask

    initial begin
        int vx[3], vy[3];
        int cx0, cy0;
        #12;
        check("reset_outputs", {busy, done, pix_valid, pix_last, pix_x, pix_y}, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("idle_after_reset", {busy, done, pix_valid}, 0);

        vx = '{2, 5, 3}; vy = '{1, 1, 3};
        run_job(vx, vy, 0, 1'b0, 0);
        run_job(vx, vy, 1, 1'b0, 0);
        run_job(vx, vy, 0, 1'b1, 0);
        vx = '{7, 7, 7}; vy = '{9, 9, 9};
        run_job(vx, vy, 0, 1'b0, 0);
        vx = '{-5, 3, 1}; vy = '{-5, -2, 4};
        run_job(vx, vy, 2, 1'b0, 0);
        vx = '{400, 500, 350}; vy = '{10, 20, 30};
        run_job(vx, vy, 0, 1'b0, 0);
        vx = '{315, 330, 318}; vy = '{235, 250, 237};
        run_job(vx, vy, 0, 1'b0, 0);
        vx = '{2, 5, 3}; vy = '{1, 1, 3};
        run_job(vx, vy, 0, 1'b0, 5);
        run_job(vx, vy, 0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            cx0 = int'($urandom_range(0, 380)) - 30;
            cy0 = int'($urandom_range(0, 300)) - 30;
            if (i % 6 == 5) cx0 = -60;
            for (int j = 0; j < 3; j++) begin
                vx[j] = cx0 + int'($urandom_range(0, 16)) - 8;
                vy[j] = cy0 + int'($urandom_range(0, 16)) - 8;
            end
            run_job(vx, vy, 2, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
